// File: rtl/core_seq_if.sv
// Signal bundle between core_seq and its host/core neighbours.
// The master modport is the sequencer side; slave is the host/core side.
interface core_seq_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
    logic        out_valid;
    logic [7:0]  onij;

    modport master (
        input  start, ofifo_valid,
        output inst, core_rst, busy, done, kij, out_valid, onij
    );

    modport slave (
        output start, ofifo_valid,
        input  inst, core_rst, busy, done, kij, out_valid, onij
    );
endinterface

// File: rtl/core_seq.sv
// Layer sequencer for core: per-kij weight/activation load, execute and psum write-back,
// then output-stationary accumulation per output pixel. Optional CORE_SEQ_PERF_EN adds cycle_cnt.
module core_seq #(
    parameter int row         = 8,
    parameter int col         = 8,
    parameter int nij_w       = 6,
    parameter int kij_sqrt    = 3,
    parameter int addr_w      = 11,
    parameter int wgt_base    = 1024,
    parameter int psum_stride = 37,
    parameter int gap_cycles  = 10,
    parameter int rst_cycles  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CORE_SEQ_PERF_EN
    output logic [31:0] cycle_cnt,
`endif
    core_seq_if.master  bus
);

    localparam int len_nij  = nij_w * nij_w;
    localparam int len_kij  = kij_sqrt * kij_sqrt;
    localparam int o_w      = nij_w - kij_sqrt + 1;
    localparam int len_onij = o_w * o_w;
    localparam int exec_len = len_nij + row + col;

    localparam logic [33:0] inst_idle = 34'h1_800C_0000;

    // inst bit positions
    localparam int b_acc      = 33;
    localparam int b_cen_p    = 32;
    localparam int b_wen_p    = 31;
    localparam int b_ap_hi    = 30;
    localparam int b_ap_lo    = 20;
    localparam int b_cen_x    = 19;
    localparam int b_ax_hi    = 17;
    localparam int b_ax_lo    = 7;
    localparam int b_ofifo_rd = 6;
    localparam int b_l0_rd    = 3;
    localparam int b_l0_wr    = 2;
    localparam int b_execute  = 1;
    localparam int b_load     = 0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_KRST  = 4'd1,
        S_WL0   = 4'd2,
        S_WPE   = 4'd3,
        S_GAP   = 4'd4,
        S_AL0   = 4'd5,
        S_EXEC  = 4'd6,
        S_DRAIN = 4'd7,
        S_PWR   = 4'd8,
        S_ARST  = 4'd9,
        S_ACC   = 4'd10,
        S_TAIL  = 4'd11,
        S_OUTV  = 4'd12,
        S_DONE  = 4'd13
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] t_q, t_d;
    logic [3:0]  kij_q, kij_d;
    logic [7:0]  onij_q, onij_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  c_q, c_d;
    logic [3:0]  ki_q, ki_d;
    logic [3:0]  kj_q, kj_d;

    logic [33:0] inst_q, inst_d;
    logic        core_rst_q, core_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        out_valid_q, out_valid_d;

    logic [addr_w-1:0] wl0_addr_s;
    logic [addr_w-1:0] al0_addr_s;
    logic [addr_w-1:0] pwr_addr_s;
    logic [addr_w-1:0] acc_addr_s;

    function automatic logic at_end(input logic [15:0] t, input int n);
        return t == 16'(n - 1);
    endfunction

    // Addresses are formed from next-cycle counters so they line up with the registered inst.
    assign wl0_addr_s = addr_w'(32'(wgt_base) + 32'(kij_d) * 32'(col) + 32'(t_d));
    assign al0_addr_s = addr_w'(t_d);
    assign pwr_addr_s = addr_w'(32'(kij_d) * 32'(psum_stride) + 32'(t_d));
    assign acc_addr_s = addr_w'(32'(t_d) * 32'(psum_stride)
                                + (32'(r_d) + 32'(ki_d)) * 32'(nij_w)
                                + 32'(c_d) + 32'(kj_d));

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        t_d     = t_q + 16'd1;
        kij_d   = kij_q;
        onij_d  = onij_q;
        r_d     = r_q;
        c_d     = c_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        case (state_q)
            S_IDLE: begin
                t_d = 16'd0;
                if (bus.start) begin
                    state_d = S_KRST;
                    kij_d   = 4'd0;
                    onij_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_KRST: begin
                if (at_end(t_q, rst_cycles)) begin
                    state_d = S_WL0;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_KRST;
                end
            end
            S_WL0: begin
                if (at_end(t_q, col)) begin
                    state_d = S_WPE;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_WL0;
                end
            end
            S_WPE: begin
                if (at_end(t_q, col)) begin
                    state_d = S_GAP;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_WPE;
                end
            end
            S_GAP: begin
                if (at_end(t_q, gap_cycles)) begin
                    state_d = S_AL0;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_AL0: begin
                if (at_end(t_q, len_nij)) begin
                    state_d = S_EXEC;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_AL0;
                end
            end
            S_EXEC: begin
                if (at_end(t_q, exec_len)) begin
                    state_d = S_DRAIN;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_DRAIN: begin
                t_d = 16'd0;
                if (bus.ofifo_valid) begin
                    state_d = S_PWR;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_PWR: begin
                if (at_end(t_q, len_nij)) begin
                    t_d = 16'd0;
                    if (kij_q == 4'(len_kij - 1)) begin
                        state_d = S_ARST;
                        kij_d   = 4'd0;
                        onij_d  = 8'd0;
                        r_d     = 8'd0;
                        c_d     = 8'd0;
                    end else begin
                        state_d = S_KRST;
                        kij_d   = kij_q + 4'd1;
                    end
                end else begin
                    state_d = S_PWR;
                end
            end
            S_ARST: begin
                state_d = S_ACC;
                t_d     = 16'd0;
                ki_d    = 4'd0;
                kj_d    = 4'd0;
            end
            S_ACC: begin
                // kernel (ki, kj) walks row-major alongside t
                if (kj_q == 4'(kij_sqrt - 1)) begin
                    kj_d = 4'd0;
                    ki_d = ki_q + 4'd1;
                end else begin
                    kj_d = kj_q + 4'd1;
                end
                if (at_end(t_q, len_kij)) begin
                    state_d = S_TAIL;
                    t_d     = 16'd0;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_TAIL: begin
                state_d = S_OUTV;
                t_d     = 16'd0;
            end
            S_OUTV: begin
                t_d = 16'd0;
                if (onij_q == 8'(len_onij - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ARST;
                    onij_d  = onij_q + 8'd1;
                    if (c_q == 8'(o_w - 1)) begin
                        c_d = 8'd0;
                        r_d = r_q + 8'd1;
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = 16'd0;
                onij_d  = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = 16'd0;
            end
        endcase
    end

    // Output decode from the next state, registered below
    always_comb begin
        inst_d      = inst_idle;
        core_rst_d  = 1'b0;
        busy_d      = (state_d != S_IDLE);
        done_d      = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            S_KRST, S_ARST: begin
                core_rst_d = 1'b1;
            end
            S_WL0: begin
                inst_d[b_cen_x]           = 1'b0;
                inst_d[b_ax_hi:b_ax_lo]   = wl0_addr_s;
                inst_d[b_l0_wr]           = 1'b1;
            end
            S_WPE: begin
                inst_d[b_l0_rd] = 1'b1;
                inst_d[b_load]  = 1'b1;
            end
            S_AL0: begin
                inst_d[b_cen_x]           = 1'b0;
                inst_d[b_ax_hi:b_ax_lo]   = al0_addr_s;
                inst_d[b_l0_wr]           = 1'b1;
            end
            S_EXEC: begin
                // the trailing row+col cycles only let the array flush
                if (t_d < 16'(len_nij)) begin
                    inst_d[b_execute] = 1'b1;
                    inst_d[b_l0_rd]   = 1'b1;
                end else begin
                    inst_d = inst_idle;
                end
            end
            S_PWR: begin
                inst_d[b_ofifo_rd]        = 1'b1;
                inst_d[b_cen_p]           = 1'b0;
                inst_d[b_wen_p]           = 1'b0;
                inst_d[b_ap_hi:b_ap_lo]   = pwr_addr_s;
            end
            S_ACC: begin
                // acc trails the reads by the one-cycle pmem latency
                inst_d[b_cen_p]           = 1'b0;
                inst_d[b_ap_hi:b_ap_lo]   = acc_addr_s;
                inst_d[b_acc]             = (t_d != 16'd0);
            end
            S_TAIL: begin
                inst_d[b_acc] = 1'b1;
            end
            S_OUTV: begin
                out_valid_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                inst_d = inst_idle;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            t_q         <= 16'd0;
            kij_q       <= 4'd0;
            onij_q      <= 8'd0;
            r_q         <= 8'd0;
            c_q         <= 8'd0;
            ki_q        <= 4'd0;
            kj_q        <= 4'd0;
            inst_q      <= inst_idle;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            r_q         <= r_d;
            c_q         <= c_d;
            ki_q        <= ki_d;
            kj_q        <= kj_d;
            inst_q      <= inst_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.inst      = inst_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.kij       = kij_q;
    assign bus.out_valid = out_valid_q;
    assign bus.onij      = onij_q;

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    // Count busy cycles including the current one; restart on an accepted start
    always_comb begin
        if (state_q == S_IDLE && bus.start) begin
            cycle_cnt_d = 32'd1;
        end else if (busy_d) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Performance counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq with default parameters.
module tb_core_seq;

    logic clk = 1'b0;
    logic reset;

    core_seq_if bus ();

`ifdef CORE_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    core_seq dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CORE_SEQ_PERF_EN
        .cycle_cnt (cycle_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    localparam logic [33:0] inst_idle = 34'h1_800C_0000;
    // per kij: KRST 10 + WL0 8 + WPE 8 + GAP 10 + AL0 36 + EXEC 52 + DRAIN 1 + PWR 36 = 161
    // per onij: ARST 1 + ACC 9 + TAIL 1 + OUTV 1 = 12; plus one DONE cycle
    localparam int total_busy = 9 * 161 + 16 * 12 + 1;

    // hand-computed reads for onij=5 (r=1,c=1): 37k + (1+ki)*6 + (1+kj)
    int acc_addr_tbl [9] = '{7, 45, 83, 124, 162, 200, 241, 279, 317};

    logic        acc_s, cen_p_s, wen_p_s, cen_x_s, wen_x_s;
    logic        ofifo_rd_s, l0_wr_s, execute_s;
    logic [10:0] a_p_s, a_x_s;
    assign acc_s      = bus.inst[33];
    assign cen_p_s    = bus.inst[32];
    assign wen_p_s    = bus.inst[31];
    assign a_p_s      = bus.inst[30:20];
    assign cen_x_s    = bus.inst[19];
    assign wen_x_s    = bus.inst[18];
    assign a_x_s      = bus.inst[17:7];
    assign ofifo_rd_s = bus.inst[6];
    assign l0_wr_s    = bus.inst[2];
    assign execute_s  = bus.inst[1];

    int n_checks = 0;
    int n_errors = 0;
    int ov_cnt   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.out_valid) ov_cnt <= ov_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int ov0;
        int done0;
        int busy_cycles;
        logic [13:0] exp14;
        logic [13:0] obs14;
        logic [14:0] exp15;
        logic [14:0] obs15;

        bus.start       = 1'b0;
        bus.ofifo_valid = 1'b1;
        reset           = 1'b1;
        repeat (3) tick();
        check_eq("rst_inst", 64'(bus.inst), 64'(inst_idle));
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_core_rst", 64'(bus.core_rst), 64'd0);
        check_eq("rst_kij_onij", 64'({bus.kij, bus.onij}), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        reset = 1'b0;
        tick();

        // ---------------- run 1: directed checks ----------------
        ov0   = ov_cnt;
        done0 = done_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("start_busy", 64'(bus.busy), 64'd1);
        check_eq("start_core_rst", 64'(bus.core_rst), 64'd1);
        check_eq("start_inst_idle", 64'(bus.inst), 64'(inst_idle));

        for (n = 0; n < 2000 && !(bus.kij == 4'd2 && cen_x_s == 1'b0); n++) tick();
        check_eq("wl0_k2_reached", 64'(n < 2000), 64'd1);
        bus.ofifo_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp14 = {1'b0, 1'b1, 1'b1, 11'(1040 + i)};
            obs14 = {cen_x_s, wen_x_s, l0_wr_s, a_x_s};
            check_eq("wl0_k2_addr", 64'(obs14), 64'(exp14));
            tick();
        end
        repeat (106) tick();
        for (int i = 0; i < 20; i++) begin
            check_eq("drain_idle", 64'(bus.inst), 64'(inst_idle));
            tick();
        end
        bus.ofifo_valid = 1'b1;
        tick();
        for (int i = 0; i < 36; i++) begin
            exp14 = {1'b0, 1'b0, 1'b1, 11'(74 + i)};
            obs14 = {cen_p_s, wen_p_s, ofifo_rd_s, a_p_s};
            check_eq("pwr_k2_addr", 64'(obs14), 64'(exp14));
            tick();
        end

        for (n = 0; n < 2000 && bus.kij != 4'd4; n++) tick();
        check_eq("kij4_reached", 64'(n < 2000), 64'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("start_ignored_kij", 64'({bus.busy, bus.kij}), 64'({1'b1, 4'd4}));

        for (n = 0; n < 3000 && !(bus.onij == 8'd5 && cen_p_s == 1'b0); n++) tick();
        check_eq("acc5_reached", 64'(n < 3000), 64'd1);
        for (int i = 0; i < 9; i++) begin
            exp15 = {1'b0, 1'b1, 1'(i != 0), 1'b0, 11'(acc_addr_tbl[i])};
            obs15 = {cen_p_s, wen_p_s, acc_s, 1'b0, a_p_s};
            check_eq("acc5_read", 64'(obs15), 64'(exp15));
            tick();
        end
        check_eq("acc5_tail", 64'({cen_p_s, acc_s}), 64'({1'b1, 1'b1}));
        tick();
        check_eq("acc5_out_valid", 64'({bus.out_valid, acc_s, bus.onij}), 64'({1'b1, 1'b0, 8'd5}));

        for (n = 0; n < 3000 && !bus.done; n++) tick();
        check_eq("run1_done_seen", 64'(n < 3000), 64'd1);
        repeat (10) tick();
        check_eq("run1_done_count", 64'(done_cnt - done0), 64'd1);
        check_eq("run1_out_valid_count", 64'(ov_cnt - ov0), 64'd16);
        check_eq("run1_idle_after", 64'({bus.busy, bus.done}), 64'd0);

        // ---------------- run 2: latency with 1-cycle drains ----------------
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy_cycles = 0;
        for (n = 0; n < 5000; n++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) break;
            tick();
        end
        check_eq("run2_done_seen", 64'(n < 5000), 64'd1);
        check_eq("run2_busy_cycles", 64'(busy_cycles), 64'(total_busy));
`ifdef CORE_SEQ_PERF_EN
        check_eq("perf_at_done", 64'(cycle_cnt), 64'(total_busy));
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("perf_hold", 64'(cycle_cnt), 64'(total_busy));
        end
`else
        repeat (10) tick();
`endif
        check_eq("run2_idle_after", 64'(bus.busy), 64'd0);

        // ---------------- run 3: reset mid-EXEC of kij3 ----------------
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (n = 0; n < 3000 && !(bus.kij == 4'd3 && execute_s == 1'b1); n++) tick();
        check_eq("exec_k3_reached", 64'(n < 3000), 64'd1);
        #2 reset = 1'b1;
        tick();
        check_eq("midrst_inst", 64'(bus.inst), 64'(inst_idle));
        check_eq("midrst_busy_kij", 64'({bus.busy, bus.kij}), 64'd0);
        check_eq("midrst_flags", 64'({bus.core_rst, bus.done, bus.out_valid}), 64'd0);
        reset = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("restart_krst", 64'({bus.busy, bus.core_rst, bus.kij}), 64'({1'b1, 1'b1, 4'd0}));
        for (n = 0; n < 50 && cen_x_s != 1'b0; n++) tick();
        check_eq("restart_wl0_delay", 64'(n), 64'd10);
        check_eq("restart_wl0_addr", 64'(a_x_s), 64'd1024);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
